// File: rtl/fp6_normalizer.sv
// Post-add normaliser for the small FP adder: takes the raw mantissa sum with carry and the
// common exponent, normalises it one bit per cycle and returns a packed {sign, exp, frac} result.
module fp6_normalizer #(
   parameter int MANT_W = 4,
   parameter int EXP_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sign,
   input  logic [EXP_W-1:0]          in_exp,
   input  logic [MANT_W:0]           in_mant,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXP_W+MANT_W-1:0]   out_result,
   output logic                      out_ovf,
   output logic                      out_unf,
   output logic                      out_zero
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [EXP_W-1:0]  E_MAX  = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0]  E_ZERO = {EXP_W{1'b0}};
   localparam logic [EXP_W-1:0]  E_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [MANT_W:0]   M_ZERO = {(MANT_W+1){1'b0}};
   localparam logic [MANT_W:0]   M_SAT  = {1'b0, {MANT_W{1'b1}}};

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_s;
   logic                 w_s_nxt;
   logic [EXP_W-1:0]     r_e;
   logic [EXP_W-1:0]     w_e_nxt;
   logic [MANT_W:0]      r_m;
   logic [MANT_W:0]      w_m_nxt;
   logic                 r_ovf;
   logic                 w_ovf_nxt;
   logic                 r_unf;
   logic                 w_unf_nxt;
   logic                 r_zero;
   logic                 w_zero_nxt;
   logic                 r_out_valid;
   logic                 w_out_valid_nxt;

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_s         <= 1'b0;
         r_e         <= E_ZERO;
         r_m         <= M_ZERO;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_s         <= w_s_nxt;
         r_e         <= w_e_nxt;
         r_m         <= w_m_nxt;
         r_ovf       <= w_ovf_nxt;
         r_unf       <= w_unf_nxt;
         r_zero      <= w_zero_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   // Next-state and datapath update; SHIFT checks are in strict priority order.
   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_e_nxt     = r_e;
      w_m_nxt     = r_m;
      w_ovf_nxt   = r_ovf;
      w_unf_nxt   = r_unf;
      w_zero_nxt  = r_zero;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_s_nxt     = in_sign;
               w_e_nxt     = in_exp;
               w_m_nxt     = in_mant;
               w_ovf_nxt   = 1'b0;
               w_unf_nxt   = 1'b0;
               w_zero_nxt  = 1'b0;
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (r_m == M_ZERO) begin
               w_e_nxt     = E_ZERO;
               w_s_nxt     = 1'b0;
               w_zero_nxt  = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (r_m[MANT_W] && (r_e == E_MAX)) begin
               // Carry at the top exponent: saturate rather than wrap.
               w_m_nxt     = M_SAT;
               w_ovf_nxt   = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (r_m[MANT_W]) begin
               w_m_nxt     = r_m >> 1;
               w_e_nxt     = r_e + E_ONE;
               w_state_nxt = ST_DONE;
            end else if (r_m[MANT_W-1]) begin
               w_state_nxt = ST_DONE;
            end else if (r_e == E_ZERO) begin
               w_unf_nxt   = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_m_nxt     = r_m << 1;
               w_e_nxt     = r_e - E_ONE;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_out_valid_nxt = (w_state_nxt == ST_DONE);
   end

   assign in_ready   = (r_state == ST_IDLE);
   assign out_valid  = r_out_valid;
   assign out_result = {r_s, r_e, r_m[MANT_W-2:0]};
   assign out_ovf    = r_ovf;
   assign out_unf    = r_unf;
   assign out_zero   = r_zero;

endmodule

// File: tb/tb_fp6_normalizer.sv
// Directed bench for fp6_normalizer (MANT_W=4, EXP_W=2) with hand-computed expectations.
module tb_fp6_normalizer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [1:0] in_exp;
   logic [4:0] in_mant;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_result;
   logic       out_ovf;
   logic       out_unf;
   logic       out_zero;

   int n_chk;
   int n_err;

   fp6_normalizer #(.MANT_W(4), .EXP_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_ovf    (out_ovf),
      .out_unf    (out_unf),
      .out_zero   (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation: accept, wait for result, check, optionally stall, then release.
   task automatic run_op(input string tag, input logic s, input logic [1:0] e, input logic [4:0] m,
                         input logic [5:0] res, input logic ovf, input logic unf, input logic zero,
                         input int lat_exp, input int hold);
      int lat;
      @(negedge clk);
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_valid = 1'b1;
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, "_result"}, 32'(out_result), 32'(res));
      chk({tag, "_flags"}, {29'd0, out_ovf, out_unf, out_zero}, {29'd0, ovf, unf, zero});
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_sign  = ~s;
         in_exp   = 2'd1;
         in_mant  = 5'b01000;
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_result"}, 32'(out_result), 32'(res));
         chk({tag, "_hold_flags"}, {29'd0, out_ovf, out_unf, out_zero}, {29'd0, ovf, unf, zero});
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 2'd0;
      in_mant   = 5'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {24'd0, out_valid, in_ready, out_result},
          {24'd0, 1'b0, 1'b1, 6'd0});
      chk("reset_flags", {29'd0, out_ovf, out_unf, out_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("T1_norm",  1'b0, 2'd2, 5'b01010, 6'b0_10_010, 1'b0, 1'b0, 1'b0, 2, 0);
      run_op("T2_carry", 1'b1, 2'd1, 5'b10110, 6'b1_10_011, 1'b0, 1'b0, 1'b0, 2, 0);
      run_op("T3_ovf",   1'b0, 2'd3, 5'b10001, 6'b0_11_111, 1'b1, 1'b0, 1'b0, 2, 0);
      run_op("T4_shift", 1'b0, 2'd3, 5'b00011, 6'b0_01_100, 1'b0, 1'b0, 1'b0, 4, 0);
      run_op("T5_unf",   1'b0, 2'd1, 5'b00010, 6'b0_00_100, 1'b0, 1'b1, 1'b0, 3, 0);
      run_op("T7_3shift", 1'b1, 2'd3, 5'b00001, 6'b1_00_000, 1'b0, 1'b0, 1'b0, 5, 0);
      run_op("T6_zero",  1'b1, 2'd2, 5'b00000, 6'b0_00_000, 1'b0, 1'b0, 1'b1, 2, 3);

      // Abort an operation mid-SHIFT with an asynchronous reset.
      @(negedge clk);
      in_sign  = 1'b1;
      in_exp   = 2'd3;
      in_mant  = 5'b00001;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("T6_abort_busy", 32'(in_ready), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      chk("T6_abort_outputs", {24'd0, out_valid, in_ready, out_result},
          {24'd0, 1'b0, 1'b1, 6'd0});
      chk("T6_abort_flags", {29'd0, out_ovf, out_unf, out_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("T6_after", 1'b0, 2'd2, 5'b01010, 6'b0_10_010, 1'b0, 1'b0, 1'b0, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
